// File: rtl/simple_reg_read_stage.sv
// simple_reg_read_stage: two-register read stage (S1 index capture, S2 operand capture) between issue queue and FU
// Optional macro SIMPLE_RR_BYPASS_EN forwards writeback data into S2; without it S1 stalls one cycle on a writeback hit.
module simple_reg_read_stage #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_rj_valid,
  input  logic [PREG_W-1:0]   in_rj_index,
  input  logic                in_rk_valid,
  input  logic [PREG_W-1:0]   in_rk_index,
  input  logic                in_rd_valid,
  input  logic [PREG_W-1:0]   in_rd_index,
  input  logic [25:0]         in_imm,
  input  logic [8:0]          in_op_type,
  input  logic [31:0]         in_pc,
  output logic [PREG_W-1:0]   prf_rj_addr,
  input  logic [DATA_W-1:0]   prf_rj_data,
  output logic [PREG_W-1:0]   prf_rk_addr,
  input  logic [DATA_W-1:0]   prf_rk_data,
  input  logic [3:0]          wb_valid,
  input  logic [4*PREG_W-1:0] wb_index,
  input  logic [4*DATA_W-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_src1,
  output logic [DATA_W-1:0]   out_src2,
  output logic                out_rd_valid,
  output logic [PREG_W-1:0]   out_rd_index,
  output logic [25:0]         out_imm,
  output logic [8:0]          out_op_type,
  output logic [31:0]         out_pc
);
  logic              s1_valid, s1_rj_valid, s1_rk_valid, s1_rd_valid;
  logic [PREG_W-1:0] s1_rj_index, s1_rk_index, s1_rd_index;
  logic [25:0]       s1_imm;
  logic [8:0]        s1_op_type;
  logic [31:0]       s1_pc;
  logic              s2_valid, s1_go, s1_adv;
  logic [DATA_W-1:0] src1, src2;
  logic [3:0]        rj_hit, rk_hit;

  assign prf_rj_addr = s1_rj_index;
  assign prf_rk_addr = s1_rk_index;
  assign out_valid   = s2_valid;
  assign s1_adv      = s1_valid && s1_go && (!s2_valid || out_ready);
  assign in_ready    = !flush && (!s1_valid || s1_adv);

  // Writeback ports whose index matches a valid S1 source this cycle
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rj_hit[j] = s1_rj_valid && wb_valid[j] && (wb_index[j*PREG_W +: PREG_W] == s1_rj_index);
      rk_hit[j] = s1_rk_valid && wb_valid[j] && (wb_index[j*PREG_W +: PREG_W] == s1_rk_index);
    end
  end

`ifdef SIMPLE_RR_BYPASS_EN
  assign s1_go = 1'b1;
  // Operand select: lowest-numbered matching writeback port beats the PRF; unused sources read as zero
  always_comb begin
    src1 = s1_rj_valid ? prf_rj_data : '0;
    src2 = s1_rk_valid ? prf_rk_data : '0;
    for (int j = 3; j >= 0; j--) begin
      src1 = rj_hit[j] ? wb_data[j*DATA_W +: DATA_W] : src1;
      src2 = rk_hit[j] ? wb_data[j*DATA_W +: DATA_W] : src2;
    end
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign s1_go = ~|{rj_hit, rk_hit};
  assign src1  = s1_rj_valid ? prf_rj_data : '0;
  assign src2  = s1_rk_valid ? prf_rk_data : '0;
`endif

  // S1 occupancy: flush drops everything, accept fills, advance empties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_valid <= 1'b0;
    else s1_valid <= !flush && ((in_valid && in_ready) || (s1_valid && !s1_adv));

  // S1 payload capture on accept; contents are don't-care while empty
  always_ff @(posedge clk)
    if (in_valid && in_ready) begin
      s1_rj_valid <= in_rj_valid;
      s1_rj_index <= in_rj_index;
      s1_rk_valid <= in_rk_valid;
      s1_rk_index <= in_rk_index;
      s1_rd_valid <= in_rd_valid;
      s1_rd_index <= in_rd_index;
      s1_imm      <= in_imm;
      s1_op_type  <= in_op_type;
      s1_pc       <= in_pc;
    end

  // S2 occupancy: filled by S1 advance, emptied by consumer handshake or flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s2_valid <= 1'b0;
    else s2_valid <= !flush && (s1_adv || (s2_valid && !out_ready));

  // S2 payload: operands and pass-through fields, held while the FU stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_src1     <= '0;
      out_src2     <= '0;
      out_rd_valid <= 1'b0;
      out_rd_index <= '0;
      out_imm      <= '0;
      out_op_type  <= '0;
      out_pc       <= '0;
    end else if (s1_adv) begin
      out_src1     <= src1;
      out_src2     <= src2;
      out_rd_valid <= s1_rd_valid;
      out_rd_index <= s1_rd_index;
      out_imm      <= s1_imm;
      out_op_type  <= s1_op_type;
      out_pc       <= s1_pc;
    end
endmodule

// File: tb/tb_simple_reg_read_stage.sv
// tb_simple_reg_read_stage: scoreboard bench with a PRF environment model, directed corner cases and random traffic
module tb_simple_reg_read_stage;
`ifdef SIMPLE_RR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int HIT_LAT = BYP ? 2 : 3;

  typedef struct {
    logic [31:0] s1, s2, pc;
    logic        rdv;
    logic [5:0]  rd;
    logic [25:0] imm;
    logic [8:0]  op;
    int          ecyc;
  } exp_t;

  logic         clk, rst_n, flush, in_valid, in_ready;
  logic         in_rj_valid, in_rk_valid, in_rd_valid;
  logic [5:0]   in_rj_index, in_rk_index, in_rd_index;
  logic [25:0]  in_imm;
  logic [8:0]   in_op_type;
  logic [31:0]  in_pc;
  logic [5:0]   prf_rj_addr, prf_rk_addr;
  logic [31:0]  prf_rj_data, prf_rk_data;
  logic [3:0]   wb_valid;
  logic [23:0]  wb_index;
  logic [127:0] wb_data;
  logic         out_valid, out_ready, out_rd_valid;
  logic [31:0]  out_src1, out_src2, out_pc;
  logic [5:0]   out_rd_index;
  logic [25:0]  out_imm;
  logic [8:0]   out_op_type;

  logic [31:0] prf [64];
  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  simple_reg_read_stage #(.PREG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rj_valid(in_rj_valid), .in_rj_index(in_rj_index), .in_rk_valid(in_rk_valid), .in_rk_index(in_rk_index),
    .in_rd_valid(in_rd_valid), .in_rd_index(in_rd_index), .in_imm(in_imm), .in_op_type(in_op_type), .in_pc(in_pc),
    .prf_rj_addr(prf_rj_addr), .prf_rj_data(prf_rj_data), .prf_rk_addr(prf_rk_addr), .prf_rk_data(prf_rk_data),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .out_rd_valid(out_rd_valid), .out_rd_index(out_rd_index), .out_imm(out_imm), .out_op_type(out_op_type), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file environment: combinational reads, writes land at the edge, port 0 wins a same-index conflict
  assign prf_rj_data = prf[prf_rj_addr];
  assign prf_rk_data = prf[prf_rk_addr];
  always @(posedge clk)
    for (int j = 3; j >= 0; j--)
      if (wb_valid[j]) prf[wb_index[j*6 +: 6]] <= wb_data[j*32 +: 32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inst(input logic rjv, input logic [5:0] rj, input logic rkv, input logic [5:0] rk);
    in_valid    = 1'b1;
    in_rj_valid = rjv;
    in_rj_index = rj;
    in_rk_valid = rkv;
    in_rk_index = rk;
    in_rd_valid = 1'($urandom);
    in_rd_index = 6'($urandom);
    in_imm      = 26'($urandom);
    in_op_type  = 9'($urandom);
    in_pc       = $urandom;
  endtask

  task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2, input int lat);
    exp_t e;
    e.s1 = e1; e.s2 = e2; e.pc = in_pc; e.rdv = in_rd_valid; e.rd = in_rd_index;
    e.imm = in_imm; e.op = in_op_type; e.ecyc = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(e);
  endtask

  // Present one instruction that must be accepted this cycle
  task automatic present(input logic rjv, input logic [5:0] rj, input logic rkv, input logic [5:0] rk,
                         input logic [31:0] e1, input logic [31:0] e2, input int lat);
    drive_inst(rjv, rj, rkv, rk);
    #1;
    check("accept_in_ready", in_ready, 1);
    push_exp(e1, e2, lat);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    wb_valid = 4'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic prf_write(input logic [5:0] idx, input logic [31:0] d);
    wb_valid = 4'b0001;
    wb_index[5:0] = idx;
    wb_data[31:0] = d;
    @(negedge clk);
    wb_valid = 4'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that a stalled output holds
  initial begin
    logic        held;
    logic [31:0] h_s1, h_s2, h_pc;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_src1", out_src1, h_s1);
          check("hold_src2", out_src2, h_s2);
          check("hold_pc", out_pc, h_pc);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=pc %0h required=no output (cycle %0d)", out_pc, cyc);
          end else begin
            e = sb.pop_front();
            check("src1", out_src1, e.s1);
            check("src2", out_src2, e.s2);
            check("pc", out_pc, e.pc);
            check("ctrl", {out_rd_valid, out_rd_index, out_imm, out_op_type}, {e.rdv, e.rd, e.imm, e.op});
            if (e.ecyc >= 0) check("latency", cyc, e.ecyc);
          end
        end
        held = out_valid && !out_ready && !flush;
        h_s1 = out_src1;
        h_s2 = out_src2;
        h_pc = out_pc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rj_valid = 1'b0; in_rk_valid = 1'b0; in_rd_valid = 1'b0;
    in_rj_index = '0; in_rk_index = '0; in_rd_index = '0; in_imm = '0; in_op_type = '0; in_pc = '0;
    wb_valid = 4'b0; wb_index = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_src1", out_src1, 0);
    check("reset_pc", out_pc, 0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      wb_valid = 4'b1111;
      for (int j = 0; j < 4; j++) begin
        wb_index[j*6 +: 6] = 6'(4*i + j);
        wb_data[j*32 +: 32] = $urandom;
      end
      @(negedge clk);
    end
    wb_valid = 4'b0;

    // Plain read, two-cycle latency
    prf_write(6'd5, 32'h11);
    prf_write(6'd7, 32'h22);
    present(1, 6'd5, 1, 6'd7, 32'h11, 32'h22, 2);
    idle(4);

    // Writeback to rj while in S1: forwarded, or one-cycle stall then PRF read
    present(1, 6'd5, 0, 6'd7, 32'hAB, 32'h0, HIT_LAT);
    wb_valid = 4'b0100;
    wb_index[17:12] = 6'd5;
    wb_data[95:64] = 32'hAB;
    #1;
    check("hit_in_ready", in_ready, BYP);
    @(negedge clk);
    idle(4);

    // Invalid source reads zero; two matching ports, port 0 wins
    prf_write(6'd3, 32'h5);
    present(0, 6'd5, 1, 6'd3, 32'h0, 32'h5, 2);
    idle(4);
    present(0, 6'd3, 1, 6'd3, 32'h0, 32'h77, HIT_LAT);
    wb_valid = 4'b1001;
    wb_index[5:0] = 6'd3;
    wb_data[31:0] = 32'h77;
    wb_index[23:18] = 6'd3;
    wb_data[127:96] = 32'h99;
    #1;
    check("dual_hit_in_ready", in_ready, BYP);
    @(negedge clk);
    idle(4);

    // Back-pressure: three back-to-back instructions with the FU stalled
    out_ready = 1'b0;
    present(1, 6'd7, 1, 6'd3, prf[7], prf[3], -1);
    present(1, 6'd3, 0, 6'd1, prf[3], 32'h0, -1);
    drive_inst(1, 6'd5, 1, 6'd7);
    #1;
    check("full_in_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", in_ready, 1);
    push_exp(prf[5], prf[7], -1);
    @(negedge clk);
    idle(6);

    // Flush with both stages full and a new instruction offered
    out_ready = 1'b0;
    present(1, 6'd5, 1, 6'd7, prf[5], prf[7], -1);
    present(1, 6'd7, 1, 6'd5, prf[7], prf[5], -1);
    drive_inst(1, 6'd3, 1, 6'd3);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    sb.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    idle(5);

    // Reset while instructions are in flight
    out_ready = 1'b0;
    present(1, 6'd5, 1, 6'd7, prf[5], prf[7], -1);
    present(1, 6'd7, 1, 6'd5, prf[7], prf[5], -1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(5);

    // Random traffic; writebacks rewrite current values so expectations stay timing-independent
    for (int n = 0; n < 600; n++) begin
      drive_inst(1'($urandom), 6'($urandom_range(0, 15)), 1'($urandom), 6'($urandom_range(0, 15)));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      if (flush) out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 15));
        wb_valid[j] = ($urandom_range(0, 7) == 0);
        wb_index[j*6 +: 6] = idx;
        wb_data[j*32 +: 32] = prf[idx];
      end
      #1;
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        push_exp(in_rj_valid ? prf[in_rj_index] : 32'h0, in_rk_valid ? prf[in_rk_index] : 32'h0, -1);
      @(negedge clk);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(1);
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    idle(3);
    check("sb_leftover", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/simple_reg_read_stage.md
SIMPLE_REG_READ_STAGE -- requirements
Module: simple_reg_read_stage

Interface
REQ-001 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-002 SHALL have parameter DATA_W, default 32, operand width.
REQ-003 SHALL have port clk  in  1  clock; rst_n  in  1  reset (asynchronous, active-low).
REQ-004 SHALL have port flush  in  1  pipeline flush, synchronous.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1  issue handshake from the simple issue queue.
REQ-006 SHALL have ports in_rj_valid in 1, in_rj_index in PREG_W, in_rk_valid in 1, in_rk_index in PREG_W  source operands.
REQ-007 SHALL have ports in_rd_valid in 1, in_rd_index in PREG_W, in_imm in 26, in_op_type in 9, in_pc in 32  pass-through fields.
REQ-008 SHALL have ports prf_rj_addr out PREG_W, prf_rj_data in DATA_W, prf_rk_addr out PREG_W, prf_rk_data in DATA_W  combinational PRF read ports.
REQ-009 SHALL have ports wb_valid in 4, wb_index in 4*PREG_W, wb_data in 4*DATA_W  writeback buses, port j in slice j.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1  handshake to FU.
REQ-011 SHALL have ports out_src1 out DATA_W, out_src2 out DATA_W, out_rd_valid out 1, out_rd_index out PREG_W, out_imm out 26, out_op_type out 9, out_pc out 32.

Function
REQ-012 SHALL be a two-register pipeline: S1 (index capture) and S2 (operand capture).
REQ-013 SHALL accept an instruction into S1 on in_valid && in_ready.
REQ-014 SHALL drive in_ready = !s1_valid || s1_adv, where s1_adv = s1_valid && s1_go && (!s2_valid || out_ready).
REQ-015 SHALL drive prf_rj_addr/prf_rk_addr from S1 register indices every cycle.
REQ-016 SHALL, on s1_adv, capture into S2 per source: 0 if source invalid; else lowest-numbered wb port with wb_valid[j] and index match; else PRF data.
REQ-017 SHALL re-evaluate bypass every cycle S1 is stalled (no stale operand capture).
REQ-018 SHALL give latency 2 cycles from acceptance to out_valid, sustained throughput 1 instr/cycle.
REQ-019 SHALL keep S2 contents stable while out_valid && !out_ready.
REQ-020 SHALL clear s2_valid on out_valid && out_ready unless S1 advances same cycle.
REQ-021 SHALL, on flush, clear s1_valid and s2_valid at next edge, deassert in_ready, discard any in_valid that cycle; flush overrides simultaneous accept/advance.
REQ-022 SHALL pass rd, imm, op_type, pc unchanged S1->S2.

Reset
REQ-023 SHALL clear s1_valid, s2_valid asynchronously on rst_n low; out_valid=0, in_ready=1 after reset.
REQ-024 SHALL reset S2 data outputs to 0; S1 data registers need no reset.
REQ-025 SHALL abort in-flight instructions on reset mid-operation without emitting them.

Configuration
REQ-026 SHALL use macro SIMPLE_RR_BYPASS_EN.
REQ-027 With SIMPLE_RR_BYPASS_EN defined: s1_go = 1; operands per REQ-016.
REQ-028 Without it: wb_data ignored; s1_go = 0 for the cycle any valid S1 source matches a valid wb_index, operands taken from PRF only (one-cycle stall per match, PRF write visible next cycle).

Verification
REQ-029 Reset then in_valid=1, rj=5 (PRF=0x11), rk=7 (PRF=0x22) -> out_valid at cycle+2, src1=0x11, src2=0x22.
REQ-030 Bypass on: rj=5 with wb_valid[2]=1, wb_index[2]=5, wb_data=0xAB during S1 cycle -> src1=0xAB, no stall.
REQ-031 Bypass off, same stimulus -> one stall cycle, in_ready=0 that cycle, src1 = PRF value next cycle, out_valid at cycle+3.
REQ-032 out_ready=0 for 3 cycles with 3 back-to-back inputs -> S1,S2 fill, in_ready=0, no loss/duplication, order preserved when out_ready=1.
REQ-033 flush with S1,S2 valid and in_valid=1 -> next cycle out_valid=0, no instruction emitted.
REQ-034 in_rj_valid=0, in_rk_valid=1 rk=3 (PRF=0x5) -> src1=0, src2=0x5; wb ports 0 and 3 both match rk=3 -> port 0 data chosen.
